// File: rtl/ts_pkg.sv
// Shared constants and types for the TS stream receive path.
package ts_pkg;

    localparam int unsigned TS_PKT_LEN   = 188;
    localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;

    // Field positions within the stream word {valid, sync, data[7:0]}
    localparam int unsigned VALID_BIT = 9;
    localparam int unsigned SYNC_BIT  = 8;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } ts_state_e;

endpackage

// File: rtl/ts_sync_lock.sv
// Packet lock FSM: tracks the byte index, counts good/bad sync bytes and flags
// which accepted bytes are forwarded and which count as sync errors.
module ts_sync_lock
    import ts_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 9,
    parameter int unsigned PKT_LEN    = TS_PKT_LEN,
    parameter logic [7:0]  SYNC_BYTE  = TS_SYNC_BYTE,
    parameter int unsigned LOCK_CNT   = 3,
    parameter int unsigned UNLOCK_CNT = 3
) (
    input  logic                clk1,
    input  logic                rst,
    input  logic [DATA_WIDTH:0] data_in,
    output logic                locked,
    output logic                pkt_start,
    output logic                sync_good,
    output logic                fwd_en,
    output logic                err_pulse
);

    localparam int unsigned IDX_W   = $clog2(PKT_LEN);
    localparam int unsigned MAX_CNT = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    ts_state_e        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, idx_inc;
    logic [CNT_W-1:0] good_q, good_d, good_inc;
    logic [CNT_W-1:0] bad_q, bad_d, bad_inc;
    logic             accept, flag, byte_ok, at_zero;

    always_comb begin
        accept   = data_in[VALID_BIT];
        flag     = data_in[SYNC_BIT];
        byte_ok  = flag && (data_in[7:0] == SYNC_BYTE);
        at_zero  = (idx_q == '0);
        idx_inc  = (idx_q == IDX_W'(PKT_LEN - 1)) ? '0 : idx_q + 1'b1;
        good_inc = good_q + 1'b1;
        bad_inc  = bad_q + 1'b1;

        state_d   = state_q;
        idx_d     = idx_q;
        good_d    = good_q;
        bad_d     = bad_q;
        fwd_en    = 1'b0;
        pkt_start = 1'b0;
        err_pulse = 1'b0;
        sync_good = at_zero && byte_ok;

        if (accept) begin
            unique case (state_q)
                HUNT: begin
                    if (byte_ok) begin
                        state_d = VERIFY;
                        good_d  = CNT_W'(1);
                        idx_d   = IDX_W'(1);
                    end
                end
                VERIFY: begin
                    idx_d = idx_inc;
                    if (at_zero) begin
                        if (byte_ok) begin
                            good_d = good_inc;
                            // The byte that completes lock is already forwarded.
                            if (good_inc == CNT_W'(LOCK_CNT)) begin
                                state_d   = LOCKED;
                                bad_d     = '0;
                                fwd_en    = 1'b1;
                                pkt_start = 1'b1;
                            end
                        end else begin
                            state_d = HUNT;
                        end
                    end
                end
                LOCKED: begin
                    idx_d     = idx_inc;
                    fwd_en    = 1'b1;
                    pkt_start = at_zero;
                    if (at_zero) begin
                        if (byte_ok) begin
                            bad_d = '0;
                        end else begin
                            bad_d     = bad_inc;
                            err_pulse = 1'b1;
                            if (bad_inc == CNT_W'(UNLOCK_CNT)) begin
                                state_d = HUNT;
                            end
                        end
                    end else if (flag) begin
                        err_pulse = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q <= HUNT;
            idx_q   <= '0;
            good_q  <= '0;
            bad_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
        end
    end

    assign locked = (state_q == LOCKED);

endmodule

// File: rtl/ts_stream_demux.sv
// Demultiplexes a locked TS byte stream onto four per-channel byte interfaces.
// Define TS_ERR_CNT_EN to build the saturating sync-error counter.
module ts_stream_demux
    import ts_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 9,
    parameter int unsigned PKT_LEN    = TS_PKT_LEN,
    parameter logic [7:0]  SYNC_BYTE  = TS_SYNC_BYTE,
    parameter int unsigned LOCK_CNT   = 3,
    parameter int unsigned UNLOCK_CNT = 3
) (
    input  logic                clk1,
    input  logic                rst,
    input  logic [DATA_WIDTH:0] data_in,
    input  logic [1:0]          ch_sel,
    output logic [7:0]          data_s1,
    output logic [7:0]          data_s2,
    output logic [7:0]          data_s3,
    output logic [7:0]          data_s4,
    output logic [3:0]          valid_out,
    output logic [3:0]          sync_out,
    output logic                locked,
    output logic [15:0]         pkt_err_cnt
);

    logic            pkt_start, sync_good, fwd_en, err_pulse;
    logic [1:0]      ch_act_q, ch_act_d;
    logic [3:0][7:0] data_q, data_d;
    logic [3:0]      valid_q, valid_d;
    logic [3:0]      sync_q, sync_d;

    ts_sync_lock #(
        .DATA_WIDTH (DATA_WIDTH),
        .PKT_LEN    (PKT_LEN),
        .SYNC_BYTE  (SYNC_BYTE),
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) u_sync_lock (
        .clk1      (clk1),
        .rst       (rst),
        .data_in   (data_in),
        .locked    (locked),
        .pkt_start (pkt_start),
        .sync_good (sync_good),
        .fwd_en    (fwd_en),
        .err_pulse (err_pulse)
    );

    // The index-0 byte already goes to the newly selected channel.
    always_comb begin
        ch_act_d = pkt_start ? ch_sel : ch_act_q;
        data_d   = data_q;
        valid_d  = '0;
        sync_d   = '0;
        if (fwd_en) begin
            data_d[ch_act_d]  = data_in[7:0];
            valid_d[ch_act_d] = 1'b1;
            sync_d[ch_act_d]  = pkt_start && sync_good;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            ch_act_q <= '0;
            data_q   <= '0;
            valid_q  <= '0;
            sync_q   <= '0;
        end else begin
            ch_act_q <= ch_act_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            sync_q   <= sync_d;
        end
    end

    assign data_s1   = data_q[0];
    assign data_s2   = data_q[1];
    assign data_s3   = data_q[2];
    assign data_s4   = data_q[3];
    assign valid_out = valid_q;
    assign sync_out  = sync_q;

`ifdef TS_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk1) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (err_pulse && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign pkt_err_cnt = err_cnt_q;
`else
    logic unused_err_pulse;

    assign unused_err_pulse = err_pulse;
    assign pkt_err_cnt      = 16'h0;
`endif

endmodule
